apb3_master_arbiter: RTL and testbench

//   Lets N_REQ independent requesters share one APB3 master port.

---
 rtl/apb3_master_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_apb3_master_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master_arbiter.sv
// Round-robin arbiter that lets N_REQ valid/ready requesters share one APB3
// master port, sequencing SETUP/ACCESS and returning a one-cycle completion.
`timescale 1ns/1ps
module apb3_master_arbiter #(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [ADDR_WIDTH-1:0]       PADDR,
    output logic [DATA_WIDTH-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        last;
    logic [IDX_W-1:0]        last_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;

    logic                    lo_found;
    logic                    hi_found;
    logic [IDX_W-1:0]        lo_idx;
    logic [IDX_W-1:0]        hi_idx;
    logic                    g_found;
    logic [IDX_W-1:0]        g_idx;
    logic [N_REQ-1:0]        grant;

    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    logic                    handshake;
    logic                    timeout_hit;
    logic                    access_done;

    logic                    psel_nxt;
    logic                    penable_nxt;
    logic                    pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt;
    logic [N_REQ-1:0]        rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_nxt;
    logic                    rsp_err_nxt;

    // Round-robin pick: lowest valid index above last, else lowest valid overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
            if (req_valid[i] && (IDX_W'(i) > last)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
        end
        g_found = lo_found;
        g_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign grant     = g_found ? (N_REQ'(1) << g_idx) : '0;
    assign req_ready = (arst_n && (state == IDLE)) ? grant : '0;
    assign handshake = (state == IDLE) && g_found;

    // Command fields of the granted requester.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == g_idx) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !PREADY && (cnt == CNT_LAST);
    assign access_done = (state == ACCESS) && (PREADY || timeout_hit);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered bus and response outputs.
    always_comb begin
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        pwrite_nxt    = 1'b0;
        paddr_nxt     = '0;
        pwdata_nxt    = '0;
        rsp_valid_nxt = '0;
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
        last_nxt      = last;
        cnt_nxt       = cnt;
        case (state)
            IDLE: begin
                if (handshake) begin
                    psel_nxt   = 1'b1;
                    pwrite_nxt = sel_write;
                    paddr_nxt  = sel_addr;
                    pwdata_nxt = sel_wdata;
                    last_nxt   = g_idx;
                    cnt_nxt    = '0;
                end
            end
            SETUP: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
                pwrite_nxt  = PWRITE;
                paddr_nxt   = PADDR;
                pwdata_nxt  = PWDATA;
            end
            ACCESS: begin
                if (access_done) begin
                    rsp_valid_nxt = N_REQ'(1) << last;
                    rsp_rdata_nxt = (PREADY && !PWRITE) ? PRDATA : '0;
                    rsp_err_nxt   = PREADY ? PSLVERR : 1'b1;
                end else begin
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b1;
                    pwrite_nxt  = PWRITE;
                    paddr_nxt   = PADDR;
                    pwdata_nxt  = PWDATA;
                    if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PADDR     <= paddr_nxt;
            PWDATA    <= pwdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Bench for apb3_master_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_apb3_master_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 5;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW-1:0]     PRDATA;
    logic              PREADY, PSLVERR;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    apb3_master_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (one transfer record) ----------------
    bit            m_busy;
    int            m_phase;      // 0 = setup cycle, k >= 1 = k-th access cycle
    int            m_owner;
    int            m_last;
    bit            m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;
    bit            m_rsp_err;

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge arst_n) begin : model
        int g;
        if (!arst_n) begin
            m_busy      <= 1'b0;
            m_phase     <= 0;
            m_owner     <= 0;
            m_last      <= N - 1;
            m_write     <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_rsp_valid <= '0;
            m_rsp_rdata <= '0;
            m_rsp_err   <= 1'b0;
        end else begin
            m_rsp_valid <= '0;
            m_rsp_rdata <= '0;
            m_rsp_err   <= 1'b0;
            if (!m_busy) begin
                g = rr_pick(req_valid, m_last);
                if (g >= 0) begin
                    m_busy  <= 1'b1;
                    m_phase <= 0;
                    m_owner <= g;
                    m_last  <= g;
                    m_write <= req_write[g];
                    m_addr  <= req_addr[g*AW +: AW];
                    m_wdata <= req_wdata[g*DW +: DW];
                end
            end else if (m_phase == 0) begin
                m_phase <= 1;
            end else if (PREADY) begin
                m_busy      <= 1'b0;
                m_rsp_valid <= N'(1) << m_owner;
                m_rsp_rdata <= m_write ? '0 : PRDATA;
                m_rsp_err   <= PSLVERR;
            end else if (TO != 0 && m_phase == TO) begin
                m_busy      <= 1'b0;
                m_rsp_valid <= N'(1) << m_owner;
                m_rsp_err   <= 1'b1;
            end else begin
                m_phase <= m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] exp_ready;
        int g;
        if (cmp_en) begin
            g = rr_pick(req_valid, m_last);
            exp_ready = (arst_n && !m_busy && g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("PSEL",      PSEL,      m_busy);
            chk("PENABLE",   PENABLE,   m_busy && m_phase >= 1);
            chk("PWRITE",    PWRITE,    m_busy ? m_write : 1'b0);
            chk("PADDR",     PADDR,     m_busy ? m_addr : '0);
            chk("PWDATA",    PWDATA,    m_busy ? m_wdata : '0);
            chk("rsp_valid", rsp_valid, m_rsp_valid);
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err",   rsp_err,   m_rsp_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        arst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int pen;
        logic [AW-1:0] seen_addr[4];
        logic [N-1:0]  seen_rsp[4];
        int ns, nr;
        int hs[$];
        bit [8:1] pat;

        clear_inputs();
        arst_n = 1'b0;
        tick();
        tick();
        // reset state, including req_ready with requests pending
        req_valid = 3'b111;
        #1;
        chk("rst_PSEL", PSEL, 0);
        chk("rst_PENABLE", PENABLE, 0);
        chk("rst_PADDR", PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        cmp_en = 1'b1;

        // single read
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        PRDATA = 32'hCAFE0001;
        #1 chk("rd_ready_c0", req_ready, 3'b001);
        tick(); req_valid = '0;
        chk("rd_PSEL_c1", PSEL, 1);
        chk("rd_PENABLE_c1", PENABLE, 0);
        chk("rd_PADDR_c1", PADDR, 32'h10);
        tick();
        chk("rd_PSEL_c2", PSEL, 1);
        chk("rd_PENABLE_c2", PENABLE, 1);
        PREADY = 1'b1;
        tick();
        PREADY = 1'b0;
        chk("rd_rsp_valid_c3", rsp_valid, 3'b001);
        chk("rd_rsp_rdata_c3", rsp_rdata, 32'hCAFE0001);
        chk("rd_rsp_err_c3", rsp_err, 0);
        chk("rd_PSEL_c3", PSEL, 0);

        // round robin between req0 and req1
        do_reset();
        PREADY = 1'b1;
        set_req(0, 1'b1, 1'b1, 32'h100, 32'hA0);
        set_req(1, 1'b1, 1'b1, 32'h200, 32'hB0);
        ns = 0; nr = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 10) req_valid = '0;
            if (PSEL && !PENABLE && ns < 4) begin seen_addr[ns] = PADDR; ns++; end
            if (rsp_valid != '0 && nr < 4) begin seen_rsp[nr] = rsp_valid; nr++; end
        end
        chk("rr_setups", ns, 4);
        chk("rr_rsps", nr, 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_paddr", (k < ns) ? seen_addr[k] : '1, (k % 2 == 0) ? 32'h100 : 32'h200);
            chk("rr_rsp_owner", (k < nr) ? seen_rsp[k] : '1, (k % 2 == 0) ? 3'b001 : 3'b010);
        end
        PREADY = 1'b0;

        // wait states then slave error on a write
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h4, 32'h5555);
        PRDATA = 32'hDEADBEEF;
        pen = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            req_valid = '0;
            if (PENABLE) pen++;
            PREADY  = (c == 5);
            PSLVERR = (c == 5);
            if (c == 6) begin
                chk("ws_rsp_valid", rsp_valid, 3'b001);
                chk("ws_rsp_err", rsp_err, 1);
                chk("ws_rsp_rdata", rsp_rdata, 0);
            end
        end
        chk("ws_penable_cycles", pen, 4);

        // timeout, then the queued requester is granted
        do_reset();
        PRDATA = 32'h12345678;
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
        pen = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (PENABLE) pen++;
            if (c == 6) chk("to_PSEL_last_access", PSEL, 1);
            if (c == 7) begin
                chk("to_PSEL_drop", PSEL, 0);
                chk("to_rsp_valid", rsp_valid, 3'b001);
                chk("to_rsp_err", rsp_err, 1);
                chk("to_rsp_rdata", rsp_rdata, 0);
                chk("to_next_grant", req_ready, 3'b010);
            end
        end
        chk("to_access_cycles", pen, 5);
        tick();
        req_valid = '0;
        chk("to_next_PADDR", PADDR, 32'h30);
        PREADY = 1'b1;
        tick(); tick(); tick();
        PREADY = 1'b0;

        // async reset in the middle of ACCESS
        do_reset();
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h77);
        tick(); req_valid = '0;
        tick();
        #1 arst_n = 1'b0;
        #1;
        chk("rma_PSEL", PSEL, 0);
        chk("rma_PENABLE", PENABLE, 0);
        chk("rma_PWRITE", PWRITE, 0);
        chk("rma_PADDR", PADDR, 0);
        chk("rma_PWDATA", PWDATA, 0);
        chk("rma_rsp_valid", rsp_valid, 0);
        set_req(1, 1'b1, 1'b0, 32'h50, 32'h0);
        #1 chk("rma_ready_in_reset", req_ready, 0);
        tick(); tick();
        arst_n = 1'b1;
        #1 chk("rma_ready_after", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("rma_PSEL_after", PSEL, 1);
        chk("rma_PADDR_after", PADDR, 32'h50);
        chk("rma_no_rsp", rsp_valid, 0);
        PREADY = 1'b1;
        tick(); tick(); tick();

        // back-to-back reads with zero-wait slave
        do_reset();
        PREADY = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
        hs = {};
        pat = '0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin tick(); pat[c] = PSEL; end
            if (c == 7) req_valid[0] = 1'b0;
            PRDATA = $urandom;
            #1;
            if (req_valid[0] && req_ready[0]) hs.push_back(c);
        end
        chk("b2b_hs_count", hs.size(), 3);
        for (int k = 0; k < 3; k++)
            chk("b2b_hs_cycle", (k < hs.size()) ? hs[k] : -1, 3 * k);
        chk("b2b_psel_pattern", pat, 8'b11011011);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit slow;
            slow = ((c / 500) % 2) == 1;
            req_valid = N'($urandom);
            req_write = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]  = $urandom;
                req_wdata[i*DW +: DW] = $urandom;
            end
            PREADY  = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 3) == 0);
            if (c % 1300 == 650) begin
                #2 arst_n = 1'b0;
                #1 arst_n = 1'b1;
            end
            tick();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
